keypad_entry_ctrl: RTL and testbench
====================================

Name: keypad_entry_ctrl

Overview:
- Sequencing controller between the keypad decode path and an external BCD arithmetic unit.
- Turns debounced key codes into two 3-digit BCD operands, then hands them to the arithmetic unit with a req/done handshake.
- Captures the 4-digit BCD result and drives the three display digits feeding the multiplexed 7-segment driver.
- Replaces the ad-hoc digit-write logic in the top level; '*' clears, '#' advances.

Parameters:
- TIMEOUT_CYCLES, 1000: max cycles op_req may stay high without op_done before entering ERROR.
- TO_W, $clog2(TIMEOUT_CYCLES+1): timeout counter width (derived; do not override).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- key_valid  input  1  level high while a debounced, decodable key is held
- key_code  input  4  decoded key: 0-9 digit, 10 '*', 11 '#', 12-15 unused
- op_a  output  12  operand A, 3 BCD digits, [3:0] = units
- op_b  output  12  operand B, same packing
- op_req  output  1  request to arithmetic unit
- op_done  input  1  arithmetic unit completion strobe
- op_result  input  16  4 BCD digits, valid while op_done=1
- disp_digit0  output  4  units digit to display
- disp_digit1  output  4  tens digit to display
- disp_digit2  output  4  hundreds digit to display
- phase  output  2  0 ENTER_A, 1 ENTER_B, 2 WAIT, 3 SHOW/ERROR
- ovf  output  1  result exceeded 999
- err  output  1  arithmetic timeout

Behaviour:
- Reset: one clk edge with rst_n=0 forces the following. State ENTER_A. op_a, op_b, result register and disp_digit* all 0. op_req=0, ovf=0, err=0, phase=0. Timeout counter 0. Digit counts 0. key_valid_d=0. rst_n overrides everything, including mid-handshake.
- Press event: key_valid=1 with registered key_valid_d=0. Exactly one event per press, regardless of hold length. key_code is sampled in the event cycle. The resulting register update is visible the cycle after that edge (1-cycle latency). Codes 12-15 are ignored in every state.
- Digit entry (ENTER_A into op_a, ENTER_B into op_b):
  - Shift-left: hundreds<=tens, tens<=units, units<=key.
  - A per-operand count (0..3) increments on each accepted digit.
  - When count==3, further digits are ignored; there is no wrap and the value is unchanged.
- FSM transitions:
  - ENTER_A, '#' -> ENTER_B; op_b=0, count_b=0. Accepted with count_a=0, giving A=000.
  - ENTER_B, '#' -> WAIT; op_req<=1, timeout counter<=0.
  - WAIT: digits and '#' are ignored. op_a and op_b are held stable while op_req=1.
    - At an edge with op_req=1 and op_done=1: capture op_result, op_req<=0, ovf<=(op_result[15:12]!=0), go to SHOW.
    - Otherwise the counter increments. At the edge where it reaches TIMEOUT_CYCLES-1 without op_done: op_req<=0, err<=1, go to ERROR.
    - op_done on that same final edge wins over the timeout.
  - SHOW: '#' ignored. A digit press clears op_a, op_b, ovf and both counts, goes to ENTER_A, and loads that digit as A units in the same edge.
  - ERROR: only '*' or reset exits.
  - '*' in any state: op_a, op_b, counts, result, ovf and err all 0; op_req<=0; go to ENTER_A.
    - '*' has priority over a simultaneous op_done; that result is discarded.
    - op_done while op_req=0 is ignored.
- Display mux (registered with state, updates with the same 1-cycle latency):
  - ENTER_A: op_a.
  - ENTER_B and WAIT: op_b.
  - SHOW: result[11:0], i.e. the low 3 digits even when ovf=1.
  - ERROR: 0,0,0.
- phase=3 in both SHOW and ERROR; distinguish them by err.
- No arithmetic is done here; all values pass through as BCD unchanged.

Test Plan:
- Reset, press 1,2,3,4 (each held 5 cycles, gaps of 3) -> op_a=0x123, disp=3,2,1 (digit0..2); the 4th press is ignored; phase=0.
- A=045 '#', B=067 '#' -> op_req rises the cycle after '#' with op_a=0x045, op_b=0x067. Drive op_done=1, op_result=0x0112 after 7 cycles -> op_req=0 next cycle, disp=2,1,1, ovf=0, phase=3.
- A=999, B=999, result 0x1998 -> disp=8,9,9, ovf=1. Then press 5 -> phase=0, op_a=0x005, ovf=0.
- TIMEOUT_CYCLES=8, enter A and B, never assert op_done -> op_req high exactly 8 cycles, then err=1, disp=0,0,0. Digits and '#' are ignored. '*' -> err=0, phase=0.
- Key held 50 cycles -> single digit entered. '*' pressed in the same cycle op_done=1 -> result discarded, phase=0, all outputs 0.
- rst_n=0 for one cycle while op_req=1 -> next cycle op_req=0 and all outputs at reset values. A late op_done is ignored.

Source files
------------

// File: rtl/keypad_entry_ctrl_if.sv
// keypad_entry_ctrl_if: keypad, arithmetic-unit and display signals of the
// keypad entry controller.
//   key_valid, key_code : debounced key level and decoded code (0-9, 10 '*', 11 '#')
//   op_a, op_b          : 3-digit BCD operands, [3:0] = units
//   op_req, op_done     : request to / completion strobe from the arithmetic unit
//   op_result           : 4-digit BCD result, valid while op_done=1
//   disp_digit0..2      : units/tens/hundreds digits for the 7-segment driver
//   phase, ovf, err     : entry phase, result > 999, arithmetic timeout
// master = the controller, slave = its environment.
interface keypad_entry_ctrl_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [11:0] op_a;
    logic [11:0] op_b;
    logic        op_req;
    logic        op_done;
    logic [15:0] op_result;
    logic [3:0]  disp_digit0;
    logic [3:0]  disp_digit1;
    logic [3:0]  disp_digit2;
    logic [1:0]  phase;
    logic        ovf;
    logic        err;

    modport master (
        input  key_valid, key_code, op_done, op_result,
        output op_a, op_b, op_req, disp_digit0, disp_digit1, disp_digit2,
               phase, ovf, err
    );

    modport slave (
        output key_valid, key_code, op_done, op_result,
        input  op_a, op_b, op_req, disp_digit0, disp_digit1, disp_digit2,
               phase, ovf, err
    );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: collects two 3-digit BCD operands from keypad presses,
// hands them to an external BCD arithmetic unit with a req/done handshake and
// shows the entered operand or the low three result digits on the display.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : keypad_entry_ctrl_if.master (keypad in, operands/handshake, display out)
module keypad_entry_ctrl #(
    parameter  int TIMEOUT_CYCLES = 1000,
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    keypad_entry_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_ENTER_A,
        S_ENTER_B,
        S_WAIT,
        S_SHOW,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [11:0]       a_q, a_d, b_q, b_d, res_q, res_d, disp_q, disp_d;
    logic [1:0]        cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [1:0]        phase_q, phase_d;
    logic              req_q, req_d, ovf_q, ovf_d, err_q, err_d;
    logic              kv_q;
    logic [TO_W-1:0]   tmo_q, tmo_d;
    logic              press, is_digit, is_star, is_hash;

    // One event per press: rising edge of key_valid against its registered copy.
    always_comb begin
        press    = bus.key_valid & ~kv_q;
        is_digit = (bus.key_code <= 4'd9);
        is_star  = (bus.key_code == 4'd10);
        is_hash  = (bus.key_code == 4'd11);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        req_d   = req_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        tmo_d   = tmo_q;

        if (press && is_star) begin
            // '*' outranks a coincident op_done; that result is dropped.
            state_d = S_ENTER_A;
            a_d     = '0;
            b_d     = '0;
            res_d   = '0;
            cnt_a_d = '0;
            cnt_b_d = '0;
            req_d   = 1'b0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
            tmo_d   = '0;
        end else begin
            unique case (state_q)
                S_ENTER_A: begin
                    if (press && is_digit && cnt_a_q != 2'd3) begin
                        a_d     = {a_q[7:0], bus.key_code};
                        cnt_a_d = cnt_a_q + 2'd1;
                    end else if (press && is_hash) begin
                        state_d = S_ENTER_B;
                        b_d     = '0;
                        cnt_b_d = '0;
                    end
                end
                S_ENTER_B: begin
                    if (press && is_digit && cnt_b_q != 2'd3) begin
                        b_d     = {b_q[7:0], bus.key_code};
                        cnt_b_d = cnt_b_q + 2'd1;
                    end else if (press && is_hash) begin
                        state_d = S_WAIT;
                        req_d   = 1'b1;
                        tmo_d   = '0;
                    end
                end
                S_WAIT: begin
                    // op_done on the last allowed edge still wins over the timeout.
                    if (req_q && bus.op_done) begin
                        state_d = S_SHOW;
                        res_d   = bus.op_result[11:0];
                        req_d   = 1'b0;
                        ovf_d   = (bus.op_result[15:12] != 4'd0);
                    end else if (tmo_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d = S_ERROR;
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TO_W'(1);
                    end
                end
                S_SHOW: begin
                    // A digit starts a fresh entry and becomes A's units digit.
                    if (press && is_digit) begin
                        state_d = S_ENTER_A;
                        a_d     = {8'h00, bus.key_code};
                        b_d     = '0;
                        cnt_a_d = 2'd1;
                        cnt_b_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
                S_ERROR: ;
                default: state_d = S_ENTER_A;
            endcase
        end

        // Display and phase are registered from next-state values so they
        // track the operands with the same one-cycle latency.
        unique case (state_d)
            S_ENTER_A:        disp_d = a_d;
            S_ENTER_B, S_WAIT: disp_d = b_d;
            S_SHOW:           disp_d = res_d;
            default:          disp_d = '0;
        endcase

        unique case (state_d)
            S_ENTER_A: phase_d = 2'd0;
            S_ENTER_B: phase_d = 2'd1;
            S_WAIT:    phase_d = 2'd2;
            default:   phase_d = 2'd3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            disp_q  <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            phase_q <= '0;
            req_q   <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            kv_q    <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            disp_q  <= disp_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            phase_q <= phase_d;
            req_q   <= req_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            kv_q    <= bus.key_valid;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.op_a        = a_q;
    assign bus.op_b        = b_q;
    assign bus.op_req      = req_q;
    assign bus.disp_digit0 = disp_q[3:0];
    assign bus.disp_digit1 = disp_q[7:4];
    assign bus.disp_digit2 = disp_q[11:8];
    assign bus.phase       = phase_q;
    assign bus.ovf         = ovf_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
module tb_keypad_entry_ctrl;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    keypad_entry_ctrl_if bus();

    keypad_entry_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: operands kept as decimal integers, phases as plain numbers
    // (0 A, 1 B, 2 WAIT, 3 SHOW, 4 ERROR), wait measured in elapsed edges.
    int          m_phase, m_a, m_b, m_na, m_nb, m_wait;
    logic [11:0] m_res;
    logic        m_req, m_ovf, m_err, m_kvd;

    typedef struct {
        logic [3:0]  code;
        int          hold;
        logic [11:0] a;
        logic [11:0] b;
        logic [1:0]  ph;
        logic [11:0] disp;
    } pvec_t;

    pvec_t tbl[10];

    function automatic logic [11:0] bcd3(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    function automatic logic [11:0] mdl_disp();
        case (m_phase)
            0:       return bcd3(m_a);
            1, 2:    return bcd3(m_b);
            3:       return m_res;
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [40:0] mdl_vec();
        logic [1:0] ph;
        ph = (m_phase >= 3) ? 2'd3 : 2'(m_phase);
        return {bcd3(m_a), bcd3(m_b), m_req, mdl_disp(), ph, m_ovf, m_err};
    endfunction

    function automatic logic [40:0] dut_vec();
        return {bus.op_a, bus.op_b, bus.op_req, bus.disp_digit2, bus.disp_digit1,
                bus.disp_digit0, bus.phase, bus.ovf, bus.err};
    endfunction

    function automatic logic [11:0] dut_disp();
        return {bus.disp_digit2, bus.disp_digit1, bus.disp_digit0};
    endfunction

    task automatic mdl_clear();
        m_phase = 0; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_wait = 0;
        m_res = '0; m_req = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
    endtask

    task automatic mdl_step(input logic r, input logic kv, input logic [3:0] code,
                            input logic d, input logic [15:0] res);
        logic ev;
        if (!r) begin
            mdl_clear();
            m_kvd = 1'b0;
            return;
        end
        ev    = kv && !m_kvd;
        m_kvd = kv;
        if (ev && code == 4'd10) begin
            mdl_clear();
            return;
        end
        case (m_phase)
            0: if (ev && code < 4'd10 && m_na < 3) begin
                   m_a = m_a * 10 + int'(code); m_na++;
               end else if (ev && code == 4'd11) begin
                   m_phase = 1; m_b = 0; m_nb = 0;
               end
            1: if (ev && code < 4'd10 && m_nb < 3) begin
                   m_b = m_b * 10 + int'(code); m_nb++;
               end else if (ev && code == 4'd11) begin
                   m_phase = 2; m_req = 1'b1; m_wait = 0;
               end
            2: begin
                   m_wait++;
                   if (d) begin
                       m_phase = 3; m_req = 1'b0; m_res = res[11:0];
                       m_ovf = (res[15:12] != 4'd0);
                   end else if (m_wait == TO) begin
                       m_phase = 4; m_req = 1'b0; m_err = 1'b1;
                   end
               end
            3: if (ev && code < 4'd10) begin
                   m_phase = 0; m_a = int'(code); m_na = 1; m_b = 0; m_nb = 0;
                   m_ovf = 1'b0;
               end
            default: ;
        endcase
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, check #1 after the edge.
    task automatic step(input logic r, input logic kv, input logic [3:0] code,
                        input logic d, input logic [15:0] res);
        rst_n         = r;
        bus.key_valid = kv;
        bus.key_code  = code;
        bus.op_done   = d;
        bus.op_result = res;
        mdl_step(r, kv, code, d, res);
        @(posedge clk);
        #1;
        cyc++;
        chk("model", 64'(dut_vec()), 64'(mdl_vec()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, 1'b0, 16'h0);
    endtask

    task automatic press(input logic [3:0] code, input int hold);
        for (int i = 0; i < hold; i++) step(1'b1, 1'b1, code, 1'b0, 16'h0);
        idle(3);
    endtask

    task automatic enter_ab(input logic [3:0] a, input logic [3:0] b);
        press(4'd10, 5); press(a, 5); press(4'd11, 5); press(b, 5);
        step(1'b1, 1'b1, 4'd11, 1'b0, 16'h0);
    endtask

    initial begin
        int hi;
        bus.key_valid = 1'b0; bus.key_code = 4'd0;
        bus.op_done = 1'b0;   bus.op_result = 16'h0;
        m_kvd = 1'b0;
        mdl_clear();

        // Reset
        step(1'b0, 1'b0, 4'd0, 1'b0, 16'h0);
        chk("reset_outputs", 64'(dut_vec()), 64'd0);

        // Press-level vectors
        tbl[0] = '{4'd1,  5,  12'h001, 12'h000, 2'd0, 12'h001};
        tbl[1] = '{4'd2,  5,  12'h012, 12'h000, 2'd0, 12'h012};
        tbl[2] = '{4'd3,  5,  12'h123, 12'h000, 2'd0, 12'h123};
        tbl[3] = '{4'd4,  5,  12'h123, 12'h000, 2'd0, 12'h123};
        tbl[4] = '{4'd12, 5,  12'h123, 12'h000, 2'd0, 12'h123};
        tbl[5] = '{4'd11, 5,  12'h123, 12'h000, 2'd1, 12'h000};
        tbl[6] = '{4'd6,  5,  12'h123, 12'h006, 2'd1, 12'h006};
        tbl[7] = '{4'd13, 5,  12'h123, 12'h006, 2'd1, 12'h006};
        tbl[8] = '{4'd10, 5,  12'h000, 12'h000, 2'd0, 12'h000};
        tbl[9] = '{4'd2,  50, 12'h002, 12'h000, 2'd0, 12'h002};
        for (int i = 0; i < 10; i++) begin
            press(tbl[i].code, tbl[i].hold);
            chk($sformatf("tbl%0d_op_a", i), 64'(bus.op_a), 64'(tbl[i].a));
            chk($sformatf("tbl%0d_op_b", i), 64'(bus.op_b), 64'(tbl[i].b));
            chk($sformatf("tbl%0d_phase", i), 64'(bus.phase), 64'(tbl[i].ph));
            chk($sformatf("tbl%0d_disp", i), 64'(dut_disp()), 64'(tbl[i].disp));
        end

        // Handshake: A=045, B=067, result 0112 after 7 cycles
        press(4'd10, 5); press(4'd4, 5); press(4'd5, 5); press(4'd11, 5);
        press(4'd6, 5); press(4'd7, 5);
        step(1'b1, 1'b1, 4'd11, 1'b0, 16'h0);
        chk("req_rise", 64'(bus.op_req), 64'd1);
        chk("req_op_a", 64'(bus.op_a), 64'h045);
        chk("req_op_b", 64'(bus.op_b), 64'h067);
        chk("req_phase", 64'(bus.phase), 64'd2);
        idle(6);
        chk("req_held", 64'(bus.op_req), 64'd1);
        step(1'b1, 1'b0, 4'd0, 1'b1, 16'h0112);
        chk("done_req", 64'(bus.op_req), 64'd0);
        chk("done_disp", 64'(dut_disp()), 64'h112);
        chk("done_ovf", 64'(bus.ovf), 64'd0);
        chk("done_phase", 64'(bus.phase), 64'd3);
        press(4'd11, 5);
        chk("show_hash_ignored", 64'(bus.phase), 64'd3);

        // Overflow: 999+999, then a digit starts a new entry
        press(4'd10, 5);
        for (int i = 0; i < 3; i++) press(4'd9, 5);
        press(4'd11, 5);
        for (int i = 0; i < 3; i++) press(4'd9, 5);
        step(1'b1, 1'b1, 4'd11, 1'b0, 16'h0);
        idle(2);
        step(1'b1, 1'b0, 4'd0, 1'b1, 16'h1998);
        chk("ovf_disp", 64'(dut_disp()), 64'h998);
        chk("ovf_flag", 64'(bus.ovf), 64'd1);
        press(4'd5, 5);
        chk("restart_phase", 64'(bus.phase), 64'd0);
        chk("restart_op_a", 64'(bus.op_a), 64'h005);
        chk("restart_ovf", 64'(bus.ovf), 64'd0);

        // Timeout: op_req high exactly TO cycles, then ERROR
        enter_ab(4'd1, 4'd2);
        hi = bus.op_req ? 1 : 0;
        for (int k = 0; k < 20 && bus.op_req; k++) begin
            idle(1);
            if (bus.op_req) hi++;
        end
        chk("req_high_cycles", 64'(hi), 64'(TO));
        chk("to_err", 64'(bus.err), 64'd1);
        chk("to_disp", 64'(dut_disp()), 64'h000);
        chk("to_phase", 64'(bus.phase), 64'd3);
        press(4'd7, 5); press(4'd11, 5);
        chk("err_sticky", 64'({bus.err, bus.phase, bus.op_a}), 64'({1'b1, 2'd3, 12'h001}));
        press(4'd10, 5);
        chk("err_clear", 64'({bus.err, bus.phase}), 64'd0);

        // op_done on the final allowed edge beats the timeout
        enter_ab(4'd1, 4'd2);
        idle(TO - 1);
        step(1'b1, 1'b0, 4'd0, 1'b1, 16'h0345);
        chk("late_done_wins", 64'({bus.err, bus.phase, dut_disp()}), 64'({1'b0, 2'd3, 12'h345}));

        // '*' together with op_done discards the result
        enter_ab(4'd3, 4'd4);
        idle(2);
        step(1'b1, 1'b1, 4'd10, 1'b1, 16'h0777);
        chk("star_beats_done", 64'(dut_vec()), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0, 1'b1, 16'h0999);
        chk("idle_done_ignored", 64'(dut_vec()), 64'd0);

        // Reset in the middle of a handshake
        enter_ab(4'd1, 4'd2);
        idle(3);
        chk("pre_rst_req", 64'(bus.op_req), 64'd1);
        step(1'b0, 1'b0, 4'd0, 1'b0, 16'h0);
        chk("mid_rst", 64'(dut_vec()), 64'd0);
        step(1'b1, 1'b0, 4'd0, 1'b1, 16'h0555);
        chk("post_rst_done", 64'(dut_vec()), 64'd0);

        // Randomized presses against the model
        for (int n = 0; n < 600; n++) begin
            int          sel, hold, gap;
            logic [3:0]  code;
            sel  = int'($urandom_range(0, 99));
            code = (sel < 60) ? 4'($urandom_range(0, 9)) :
                   (sel < 85) ? 4'd11 :
                   (sel < 90) ? 4'd10 : 4'($urandom_range(12, 15));
            hold = int'($urandom_range(1, 4));
            gap  = int'($urandom_range(0, 3));
            for (int c = 0; c < hold + gap; c++) begin
                logic        d, r;
                logic [15:0] res;
                d   = ($urandom_range(0, 5) == 0);
                r   = ($urandom_range(0, 399) != 0);
                res = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
                       4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                step(r, (c < hold), code, d, res);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
